// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: filtered hall decode, edge-aligned high-side PWM,
// per-phase dead-time, sticky invalid-hall fault and hall-edge period measurement.
module bldc_commutator #(
  parameter int unsigned PWM_WIDTH   = 8,
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned DEADTIME    = 4,
  parameter int unsigned HALL_FILTER = 3,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic                   DIR,
  input  logic [PWM_WIDTH-1:0]   DUTY,
  input  logic [2:0]             H,
  input  logic                   FAULT_CLR,
  output logic [1:0]             A,
  output logic [1:0]             B,
  output logic [1:0]             C,
  output logic                   FAULT,
  output logic [COUNT_WIDTH-1:0] EDGE_CNT,
  output logic [COUNT_WIDTH-1:0] PERIOD,
  output logic                   STALL
);
  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned HfW = $clog2(HALL_FILTER + 1);
  localparam int unsigned DtW = $clog2(DEADTIME + 1);
  localparam logic [DtW-1:0] DtMax = DtW'(DEADTIME);

  // PWM timebase
  logic [PsW-1:0]       ps_q;
  logic [PWM_WIDTH-1:0] cnt_q, shadow_q;
  logic                 tick, pwm_on;

  assign tick   = (ps_q == PsW'(PRESCALE - 1));
  assign pwm_on = (cnt_q < shadow_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ps_q     <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      ps_q <= tick ? '0 : ps_q + 1'b1;
      if (tick) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == '1) shadow_q <= DUTY;
      end
    end
  end

  // Hall filter, fault latch and speed measurement
  logic [2:0]             h_s_q, hall_q;
  logic [HfW-1:0]         stab_q;
  logic                   fault_q;
  logic [COUNT_WIDTH-1:0] edge_q, period_q, run_q;
  logic                   accept, new_bad, cur_bad;

  assign accept  = (stab_q == HfW'(HALL_FILTER)) && (h_s_q != hall_q);
  assign new_bad = (h_s_q == 3'b000) || (h_s_q == 3'b111);
  assign cur_bad = (hall_q == 3'b000) || (hall_q == 3'b111);

  always_ff @(posedge CLK) begin
    if (RST) begin
      h_s_q    <= 3'b000;
      stab_q   <= '0;
      hall_q   <= 3'b000;
      fault_q  <= 1'b0;
      edge_q   <= '0;
      period_q <= '1;
      run_q    <= '0;
    end else begin
      h_s_q <= H;
      // stab_q counts consecutive identical samples ending with h_s_q
      if (H != h_s_q) stab_q <= HfW'(1);
      else if (stab_q != HfW'(HALL_FILTER)) stab_q <= stab_q + 1'b1;

      if (accept) begin
        hall_q   <= h_s_q;
        edge_q   <= edge_q + 1'b1;
        period_q <= run_q;
        run_q    <= '0;
      end else if (run_q != '1) begin
        run_q <= run_q + 1'b1;
      end

      if (accept && new_bad) fault_q <= 1'b1;
      else if (FAULT_CLR && !cur_bad) fault_q <= 1'b0;
    end
  end

  // Commutation table and gate requests (select vectors are one-hot {C,B,A})
  logic [2:0] fwd_hi, fwd_lo, hi_sel, lo_sel, req_hi, req_lo;
  logic       drive;

  always_comb begin
    fwd_hi = 3'b000;
    fwd_lo = 3'b000;
    case (hall_q)
      3'b101:  begin fwd_hi = 3'b001; fwd_lo = 3'b010; end
      3'b100:  begin fwd_hi = 3'b001; fwd_lo = 3'b100; end
      3'b110:  begin fwd_hi = 3'b010; fwd_lo = 3'b100; end
      3'b010:  begin fwd_hi = 3'b010; fwd_lo = 3'b001; end
      3'b011:  begin fwd_hi = 3'b100; fwd_lo = 3'b001; end
      3'b001:  begin fwd_hi = 3'b100; fwd_lo = 3'b010; end
      default: ;
    endcase
    hi_sel = DIR ? fwd_lo : fwd_hi;
    lo_sel = DIR ? fwd_hi : fwd_lo;
    drive  = EN & ~fault_q;
    req_hi = drive ? (hi_sel & {3{pwm_on}}) : 3'b000;
    req_lo = drive ? lo_sel : 3'b000;
  end

  // Dead-time: off counters hold how many cycles each gate has been off, saturating
  logic [2:0]          hi_q, lo_q, hi_d, lo_d;
  logic [2:0][DtW-1:0] hi_off_q, lo_off_q, hi_off_d, lo_off_d;

  always_comb begin
    hi_d     = 3'b000;
    lo_d     = 3'b000;
    hi_off_d = hi_off_q;
    lo_off_d = lo_off_q;
    for (int i = 0; i < 3; i++) begin
      hi_d[i] = req_hi[i] && (lo_off_q[i] == DtMax);
      lo_d[i] = req_lo[i] && (hi_off_q[i] == DtMax);
      if (hi_d[i])                    hi_off_d[i] = '0;
      else if (hi_off_q[i] != DtMax)  hi_off_d[i] = hi_off_q[i] + 1'b1;
      if (lo_d[i])                    lo_off_d[i] = '0;
      else if (lo_off_q[i] != DtMax)  lo_off_d[i] = lo_off_q[i] + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hi_q     <= 3'b000;
      lo_q     <= 3'b000;
      hi_off_q <= '0;
      lo_off_q <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_off_q <= hi_off_d;
      lo_off_q <= lo_off_d;
    end
  end

  // Fault and reset blank the gates without waiting for the registered path
  logic gate_en;
  assign gate_en = ~fault_q & ~RST;

  assign A        = {hi_q[0], lo_q[0]} & {2{gate_en}};
  assign B        = {hi_q[1], lo_q[1]} & {2{gate_en}};
  assign C        = {hi_q[2], lo_q[2]} & {2{gate_en}};
  assign FAULT    = fault_q;
  assign EDGE_CNT = edge_q;
  assign PERIOD   = period_q;
  assign STALL    = (run_q == '1);

endmodule

// File: tb/tb_bldc_commutator.sv
// Scoreboard bench for bldc_commutator: a time-indexed reference model queues expected
// outputs every clock, a negedge monitor compares them against the DUT.
module tb_bldc_commutator;
  localparam int PW   = 8;
  localparam int PS   = 1;
  localparam int DT   = 4;
  localparam int HF   = 3;
  localparam int CW   = 12;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, en, dir, fault_clr;
  logic [PW-1:0] duty;
  logic [2:0]    h;
  logic [1:0]    a, b, c;
  logic          fault, stall;
  logic [CW-1:0] edge_cnt, period;

  int checks = 0;
  int failures = 0;

  bldc_commutator #(
    .PWM_WIDTH(PW), .PRESCALE(PS), .DEADTIME(DT), .HALL_FILTER(HF), .COUNT_WIDTH(CW)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en), .DIR(dir), .DUTY(duty), .H(h), .FAULT_CLR(fault_clr),
    .A(a), .B(b), .C(c), .FAULT(fault), .EDGE_CNT(edge_cnt), .PERIOD(period), .STALL(stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    a, b, c;
    logic          fault;
    logic [CW-1:0] edge_cnt, period;
    logic          stall;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: absolute edge index and per-switch "last edge it was on"
  int         en_n = 0;
  logic [2:0] m_hall;
  logic [2:0] m_hist[$];
  bit         m_fault;
  int         m_edge, m_period, m_run, m_t, m_shadow;
  bit         m_hi[3], m_lo[3];
  int         m_hlast[3], m_llast[3];

  function automatic void phases(input logic [2:0] hv, output int hp, output int lp);
    hp = -1;
    lp = -1;
    case (hv)
      3'b101: begin hp = 0; lp = 1; end
      3'b100: begin hp = 0; lp = 2; end
      3'b110: begin hp = 1; lp = 2; end
      3'b010: begin hp = 1; lp = 0; end
      3'b011: begin hp = 2; lp = 0; end
      3'b001: begin hp = 2; lp = 1; end
      default: ;
    endcase
  endfunction

  task automatic model_step();
    int cnt, hp, lp, tmp;
    bit pwm_on, drive, acc;
    bit nh[3], nl[3];
    logic [2:0] nv;
    en_n++;
    if (rst) begin
      m_hall = 3'b000; m_hist.delete(); m_fault = 0; m_edge = 0; m_period = CMAX;
      m_run = 0; m_t = 0; m_shadow = 0;
      for (int i = 0; i < 3; i++) begin
        m_hi[i] = 0; m_lo[i] = 0; m_hlast[i] = en_n; m_llast[i] = en_n;
      end
      return;
    end
    cnt    = (m_t / PS) % (1 << PW);
    pwm_on = (cnt < m_shadow);
    phases(m_hall, hp, lp);
    if (dir) begin tmp = hp; hp = lp; lp = tmp; end
    drive = en && !m_fault;
    for (int i = 0; i < 3; i++) begin
      nh[i] = drive && (hp == i) && pwm_on && (en_n - m_llast[i] > DT);
      nl[i] = drive && (lp == i) && (en_n - m_hlast[i] > DT);
    end
    for (int i = 0; i < 3; i++) begin
      m_hi[i] = nh[i];
      m_lo[i] = nl[i];
      if (nh[i]) m_hlast[i] = en_n;
      if (nl[i]) m_llast[i] = en_n;
    end
    acc = 0;
    nv  = 3'b000;
    if (m_hist.size() == HF) begin
      nv  = m_hist[0];
      acc = (nv != m_hall);
      foreach (m_hist[k]) if (m_hist[k] != nv) acc = 0;
    end
    if (acc && (nv == 3'b000 || nv == 3'b111)) m_fault = 1;
    else if (fault_clr && !(m_hall == 3'b000 || m_hall == 3'b111)) m_fault = 0;
    if (acc) begin
      m_edge = (m_edge + 1) % (1 << CW); m_period = m_run; m_run = 0; m_hall = nv;
    end else if (m_run < CMAX) begin
      m_run++;
    end
    m_hist.push_back(h);
    if (m_hist.size() > HF) void'(m_hist.pop_front());
    if ((m_t % PS) == PS - 1 && cnt == (1 << PW) - 1) m_shadow = int'(duty);
    m_t++;
  endtask

  task automatic push_expected();
    exp_t  e;
    logic  g;
    g = !m_fault && !rst;
    e.a = {m_hi[0] & g, m_lo[0] & g};
    e.b = {m_hi[1] & g, m_lo[1] & g};
    e.c = {m_hi[2] & g, m_lo[2] & g};
    e.fault    = m_fault;
    e.edge_cnt = CW'(m_edge);
    e.period   = CW'(m_period);
    e.stall    = (m_run == CMAX);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    push_expected();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e, g;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = '{a: a, b: b, c: c, fault: fault, edge_cnt: edge_cnt, period: period, stall: stall};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t got a=%b b=%b c=%b f=%b edge=%0d per=%0d stall=%b expected a=%b b=%b c=%b f=%b edge=%0d per=%0d stall=%b",
                 $time, g.a, g.b, g.c, g.fault, g.edge_cnt, g.period, g.stall,
                 e.a, e.b, e.c, e.fault, e.edge_cnt, e.period, e.stall);
      end
      checks++;
      if (a === 2'b11 || b === 2'b11 || c === 2'b11) begin
        failures++;
        $display("FAIL shoot_through t=%0t got a=%b b=%b c=%b expected no phase at 11",
                 $time, a, b, c);
      end
    end
  end

  logic [2:0] seq[6];
  int n, on_cnt, r;

  initial begin
    seq = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    rst = 1; en = 0; dir = 0; fault_clr = 0; duty = '0; h = 3'b000;
    tick(); tick();
    check("reset_period", int'(period), CMAX);
    rst = 0;

    // Forward sequence at 50% duty
    en = 1; duty = 8'h80;
    for (int s = 0; s < 6; s++) begin
      h = seq[s];
      repeat (2000) tick();
    end
    check("edge_count_seq", int'(edge_cnt), 6);

    // Dead-time on direction reversal
    h = 3'b101; duty = 8'hFF;
    n = 0;
    while (a[1] !== 1'b1 && n < 600) begin tick(); n++; end
    check("a_hi_on_before_dir", int'(a[1]), 1);
    dir = 1;
    tick();
    check("a_hi_off_next_clk", int'(a[1]), 0);
    n = 0;
    while (a[0] !== 1'b1 && n < 20) begin tick(); n++; end
    check("deadtime_gap", n, DT);
    dir = 0;
    repeat (20) tick();

    // Hall glitch, fault latch and clear
    duty = 8'h80;
    h = 3'b111; tick(); tick();
    h = 3'b101; repeat (10) tick();
    check("glitch_ignored", int'(fault), 0);
    h = 3'b111; repeat (5) tick();
    check("fault_set", int'(fault), 1);
    check("fault_gates_off", int'({a, b, c}), 0);
    fault_clr = 1; tick(); fault_clr = 0; tick();
    check("fault_clr_while_invalid", int'(fault), 1);
    h = 3'b101; repeat (6) tick();
    fault_clr = 1; tick(); fault_clr = 0;
    check("fault_cleared", int'(fault), 0);
    n = 0;
    while (a[1] !== 1'b1 && n < 600) begin tick(); n++; end
    check("drive_resumes", int'(a[1]), 1);

    // Duty bounds
    duty = 8'h00; repeat (300) tick();
    on_cnt = 0;
    repeat (600) begin tick(); on_cnt += int'(a[1]); end
    check("duty_zero_on", on_cnt, 0);
    duty = 8'hFF; repeat (300) tick();
    on_cnt = 0;
    repeat (256) begin tick(); on_cnt += int'(a[1]); end
    check("duty_full_on", on_cnt, 255);
    repeat (100) tick();
    duty = 8'h40; repeat (600) tick();

    // Randomized operation against the model
    for (int k = 0; k < 4000; k++) begin
      r = $urandom_range(0, 99);
      if (r < 3) h = seq[$urandom_range(0, 5)];
      else if (r < 4) h = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) dir = ~dir;
      if ($urandom_range(0, 299) == 0) en = ~en;
      if ($urandom_range(0, 99) == 0) duty = PW'($urandom);
      fault_clr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 0; fault_clr = 0; en = 1; dir = 0; h = 3'b101;
    repeat (10) tick();
    fault_clr = 1; tick(); fault_clr = 0;
    duty = 8'hFF; repeat (300) tick();

    // Stall, then reset mid-PWM
    repeat (CMAX + 100) tick();
    check("stall_set", int'(stall), 1);
    n = 0;
    while (a[1] !== 1'b1 && n < 600) begin tick(); n++; end
    rst = 1;
    #1;
    check("rst_gates_immediate", int'({a, b, c}), 0);
    tick(); tick();
    rst = 0;
    check("rst_edge_cnt", int'(edge_cnt), 0);
    check("rst_stall", int'(stall), 0);
    repeat (20) tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
